// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: icodes, FSM states and
// the instruction length decode reused by fetch and pc_update.
package y86_pkg;

  localparam int INSTR_BYTES = 10;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {
    S_IDLE,
    S_READ
  } fetch_state_e;

  // Byte count for an icode; unknown icodes are one byte long.
  function automatic logic [3:0] instr_len(
    input logic [3:0] icode
  );
    logic [3:0] len;
    case (icode)
      I_HALT, I_NOP, I_RET:            len = 4'd1;
      I_RRMOVQ, I_OPQ,
      I_PUSHQ, I_POPQ:                 len = 4'd2;
      I_JXX, I_CALL:                   len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:    len = 4'(INSTR_BYTES);
      default:                         len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_fetch_buffer_ram.sv
// Byte-wide instruction storage: one synchronous write port,
// one asynchronous read port (clk, wr_en/addr/data, rd_addr/data).
module instr_byte_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MEM_DEPTH];

  // Out-of-range writes are dropped silently.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < MEM_DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < MEM_DEPTH) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Multi-cycle fetch of up to INSTR_BYTES bytes into instr[0:79].
// Ports: clk, rst, load port (wr_*), req/PC in, busy/valid/instr/
// memory_error out. FETCH_SHORT_EN: stop after the icode's length.
module instr_fetch_buffer
  import y86_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int AW          = 8,
  parameter int INSTR_BYTES = y86_pkg::INSTR_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          req,
  input  logic [63:0]   PC,
  output logic          busy,
  output logic          valid,
  output logic [0:79]   instr,
  output logic          memory_error
);

  // Full 64-bit compare so huge PCs cannot wrap into range.
  localparam logic [63:0] PC_LIMIT = 64'(MEM_DEPTH - INSTR_BYTES);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [3:0]    idx_q, idx_d;
  logic [0:79]   instr_q, instr_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [3:0]    cur_len;

  instr_byte_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_addr = pc_q + AW'(idx_q);

`ifdef FETCH_SHORT_EN
  logic [3:0] len_q, len_d;

  // Length is known once byte 0 (icode in its high nibble) arrives.
  assign cur_len = (idx_q == 4'd0) ? instr_len(rd_data[7:4]) : len_q;
  assign len_d   = (state_q == S_READ) ? cur_len : len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) len_q <= 4'(INSTR_BYTES);
    else     len_q <= len_d;
  end
`else
  assign cur_len = 4'(INSTR_BYTES);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    err_d   = err_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          instr_d = '0;
          if (PC > PC_LIMIT) begin
            err_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            pc_d    = PC[AW-1:0];
            idx_d   = 4'd0;
            busy_d  = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        instr_d[{idx_q, 3'b000} +: 8] = rd_data;
        idx_d = idx_q + 4'd1;
        if (idx_q == cur_len - 4'd1) begin
          idx_d   = 4'd0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      idx_q   <= 4'd0;
      instr_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy         = busy_q;
  assign valid        = valid_q;
  assign instr        = instr_q;
  assign memory_error = err_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: stimulus pushes
// expected results, a negedge monitor pops on every valid.
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        req = 1'b0;
  logic [63:0] PC = '0;
  logic        busy, valid, memory_error;
  logic [0:79] instr;

  typedef struct {
    logic [0:79] instr;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

`ifdef FETCH_SHORT_EN
  localparam int LAT_OPQ = 2;
`else
  localparam int LAT_OPQ = 10;
`endif

  localparam logic [0:79] D128 = 80'h30F2_0000_0000_0000_000A;
  localparam logic [0:79] D148 = 80'h6020_0000_0000_0000_0000;
  localparam logic [0:79] D246 = 80'h4041_4243_4445_4647_4849;
  localparam logic [0:79] D128F = 80'h30F2_FF00_0000_0000_000A;

  instr_fetch_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .req          (req),
    .PC           (PC),
    .busy         (busy),
    .valid        (valid),
    .instr        (instr),
    .memory_error (memory_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] got,
                     input logic [79:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 80'(valid), 80'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr", instr, e.instr);
        chk("memory_error", 80'(memory_error), 80'(e.err));
        chk("valid_cycle", 80'(cyc), 80'(e.cyc));
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // lat = edges from the accepting edge to the valid edge.
  task automatic issue(input logic [63:0] pc, input logic [0:79] ei,
                       input logic ee, input int lat);
    exp_t e;
    @(posedge clk); #1;
    req = 1'b1; PC = pc;
    e.instr = ei; e.err = ee; e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_timeout", 80'(exp_q.size()), 80'(0));
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d128 [10];
    exp_t e;
    bit got_v;
    d128 = '{8'h30, 8'hF2, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_valid", 80'(valid), 80'(0));
    chk("rst_instr", instr, 80'(0));
    chk("rst_err", 80'(memory_error), 80'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) load(8'(128 + i), d128[i]);
    load(8'd148, 8'h60);
    load(8'd149, 8'h20);
    for (int i = 2; i < 10; i++) load(8'(148 + i), 8'h00);
    for (int i = 0; i < 10; i++) load(8'(246 + i), 8'(8'h40 + i));

    issue(64'd128, D128, 1'b0, 10);
    @(negedge clk);
    chk("busy_during", 80'(busy), 80'(1));
    drain();
    issue(64'd148, D148, 1'b0, LAT_OPQ);
    drain();
    issue(64'd247, 80'(0), 1'b1, 0);
    drain();
    issue(64'd246, D246, 1'b0, 10);
    drain();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 80'(0), 1'b1, 0);
    drain();
    chk("err_held", 80'(memory_error), 80'(1));

    // Back-to-back: new req in the valid cycle.
    issue(64'd148, D148, 1'b0, LAT_OPQ);
    got_v = 1'b0;
    for (int i = 0; i < 30 && !got_v; i++) begin
      @(posedge clk); #1;
      got_v = valid;
    end
    chk("b2b_valid_seen", 80'(got_v), 80'(1));
    if (got_v) begin
      req = 1'b1; PC = 64'd128;
      e.instr = D128; e.err = 1'b0; e.cyc = cyc + 11;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req = 1'b0;
    end
    drain();

    // req while busy is ignored.
    issue(64'd128, D128, 1'b0, 10);
    repeat (2) @(posedge clk);
    #1; req = 1'b1; PC = 64'd0;
    @(posedge clk); #1; req = 1'b0;
    drain();

    // Reset mid-fetch aborts with no valid.
    @(posedge clk); #1;
    req = 1'b1; PC = 64'd128;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 80'(busy), 80'(1));
    rst = 1'b1;
    #1;
    chk("abort_busy", 80'(busy), 80'(0));
    chk("abort_instr", instr, 80'(0));
    chk("abort_valid", 80'(valid), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);

    // Write collides with the read of index 2: old byte wins.
    issue(64'd128, D128, 1'b0, 10);
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 8'd130; wr_data = 8'hFF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    drain();
    issue(64'd128, D128F, 1'b0, 10);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Byte-wide instruction memory with a multi-cycle fetch engine. Sits directly upstream of the fetch stage.
- On request it reads up to 10 consecutive bytes starting at PC and assembles them into the 80-bit instr word that fetch decodes.
- Also provides a load port so benches and boot logic can program the memory.
- Fetch sees instr with byte PC in instr[0:7], the most significant byte, and byte PC+9 in instr[72:79].

Parameters:
- MEM_DEPTH, 256, number of instruction bytes stored.
- AW, 8, memory address width; must satisfy 2**AW >= MEM_DEPTH.
- INSTR_BYTES, 10, maximum Y86-64 instruction length in bytes.

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  load-port byte write strobe.
- wr_addr  in  AW  load-port byte address.
- wr_data  in  8  load-port byte data.
- req  in  1  fetch request, sampled only in IDLE.
- PC  in  64  fetch start address, latched when req is accepted.
- busy  out  1  high while a fetch is in progress.
- valid  out  1  one-cycle pulse: instr and memory_error are final.
- instr  out  80 ([0:79])  assembled instruction bytes.
- memory_error  out  1  PC out of range for the current fetch; held until the next accepted req.

Behaviour:
- Reset values: busy=0, valid=0, instr=0, memory_error=0, state=IDLE, byte index=0. Memory contents are not cleared by reset.
- States: IDLE, READ.
- IDLE, req=1 at edge N, PC <= MEM_DEPTH-INSTR_BYTES:
  - latch PC; clear instr to 0 and memory_error to 0;
  - index=0; busy=1; go to READ.
- IDLE, req=1 at edge N, PC > MEM_DEPTH-INSTR_BYTES (compare all 64 bits):
  - instr=0, memory_error=1, valid=1 from edge N for one cycle; stay in IDLE. Latency is 1.
- READ:
  - each edge captures mem[PC+index] into instr[8*index +: 8] (index 0 maps to bits 0:7) and increments index;
  - on the edge that captures index INSTR_BYTES-1: valid=1 for one cycle, busy=0, go to IDLE.
  - Full-length latency: req accepted at edge N, valid high from edge N+10 to edge N+11.
- instr and memory_error hold after valid until the next accepted req.
- A req while busy=1 is ignored, not queued. A req in the cycle valid is high is accepted, enabling back-to-back fetches.
- Writes are synchronous on wr_en and allowed at any time. Writing the address being read on the same edge returns the old byte to instr. A wr_addr >= MEM_DEPTH is dropped.
- Reset asserted mid-fetch: immediate abort, all outputs return to reset values, and no valid is issued.
- PC width 64: the range check must not wrap, so PC=2**64-1 gives memory_error.

Optional Feature:
- Macro: FETCH_SHORT_EN.
- Defined: after byte 0 is captured, the icode (instr[0:3]) sets the instruction length:
  - 0, 1, 9 (halt, nop, ret): 1 byte;
  - 2, 6, A, B: 2 bytes;
  - 7, 8 (jXX, call): 9 bytes;
  - 3, 4, 5: 10 bytes;
  - icode > B: 1 byte.
  - The fetch ends after that many bytes; unread bytes stay 0. Latency equals the byte count.
  - The range check is unchanged and always uses INSTR_BYTES.
- Undefined: all 10 bytes are always read.

Decomposition:
- Shared package y86_pkg:
  - icode localparams (I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ);
  - INSTR_BYTES;
  - function instr_len(icode) returning the byte count; used by FETCH_SHORT_EN and reusable by pc_update.
- Sub-module instr_byte_ram: MEM_DEPTH x 8 storage, one synchronous write port, one asynchronous read port. The fetch FSM stays in instr_fetch_buffer.

Test Plan:
- Load mem[128..137] = 30 F2 00 00 00 00 00 00 00 0A; req with PC=128 -> busy=1 for 10 cycles, then valid pulse with instr=80'h30F2_0000_0000_0000_000A and memory_error=0.
- Load mem[148..157] = 60 20 00..00; req with PC=148 -> instr=80'h6020_0000_0000_0000_0000. With FETCH_SHORT_EN defined, valid comes 2 cycles after req.
- req with PC=247 -> valid after 1 cycle with memory_error=1 and instr=0. Then req with PC=246 -> normal 10-cycle fetch with memory_error=0.
- Start a fetch at PC=128; pulse req with PC=0 at cycle 3 -> ignored, result is still the 128 data. Assert rst at cycle 5 -> busy=0 and instr=0 immediately, and no valid is issued.
- Write mem[130]=FF on the same edge that reads index 2 -> instr[16:23]=00. Refetch -> instr[16:23]=FF.
